// File: rtl/mem_router_pkg.sv
// Shared constants for the CPU memory router: FSM encodings and the board memory map.
package mem_router_pkg;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  // Board map; limits are exclusive.
  localparam logic [19:0] RAM_BASE = 20'h00000;
  localparam logic [19:0] RAM_LIM  = 20'h08000;
  localparam logic [19:0] CGA_BASE = 20'hB8000;
  localparam logic [19:0] CGA_LIM  = 20'hBA000;

endpackage

// File: rtl/mem_router_if.sv
// CPU-side and region-side bus of the memory router; master is the CPU/board view.
interface mem_router_if #(
  parameter int unsigned NREG = 4,
  parameter int unsigned AW   = 20,
  parameter int unsigned DW   = 8
);
  logic               req;
  logic [AW-1:0]      address;
  logic [DW-1:0]      o_data;
  logic               we;
  logic               ready;
  logic [DW-1:0]      i_data;
  logic [AW-1:0]      reg_addr;
  logic [DW-1:0]      reg_wdata;
  logic [NREG-1:0]    reg_we;
  logic [NREG*DW-1:0] reg_rdata;
  logic               fault;
  logic [AW-1:0]      fault_addr;
  logic               fault_clr;

  modport master (
    output req, address, o_data, we, reg_rdata, fault_clr,
    input  ready, i_data, reg_addr, reg_wdata, reg_we, fault, fault_addr
  );

  modport slave (
    input  req, address, o_data, we, reg_rdata, fault_clr,
    output ready, i_data, reg_addr, reg_wdata, reg_we, fault, fault_addr
  );
endinterface

// File: rtl/mem_router_decode.sv
// Combinational priority decoder: half-open [base, limit) regions, lowest index wins.
module mem_router_decode #(
  parameter int unsigned       NREG   = 4,
  parameter int unsigned       AW     = 20,
  parameter int unsigned       IW     = 2,
  parameter logic [NREG*AW-1:0] BASES  = '0,
  parameter logic [NREG*AW-1:0] LIMITS = '0
) (
  input  logic [AW-1:0] addr_i,
  output logic          hit_o,
  output logic [IW-1:0] idx_o
);

  // base >= limit can never satisfy both compares, so disabled regions need no extra term.
  always_comb begin
    logic found;
    found = 1'b0;
    idx_o = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (!found && addr_i >= BASES[i*AW +: AW] && addr_i < LIMITS[i*AW +: AW]) begin
        found = 1'b1;
        idx_o = IW'(i);
      end
    end
    hit_o = found;
  end

endmodule

// File: rtl/mem_router.sv
// CPU memory router top: accept/issue FSM, per-region wait counter, read capture, sticky fault.
module mem_router
  import mem_router_pkg::*;
#(
  parameter int unsigned        NREG     = 4,
  parameter int unsigned        AW       = 20,
  parameter int unsigned        DW       = 8,
  parameter logic [NREG*AW-1:0] BASES    = '0,
  parameter logic [NREG*AW-1:0] LIMITS   = '0,
  parameter logic [NREG*4-1:0]  WAITS    = '0,
  parameter logic [DW-1:0]      OPEN_BUS = '1
) (
  input logic         clock,
  input logic         reset,
  mem_router_if.slave bus
);

  localparam int unsigned IW = (NREG > 1) ? $clog2(NREG) : 1;

  logic [2:0]      state_q, state_d;
  logic            hit_q, we_q;
  logic [IW-1:0]   idx_q;
  logic [3:0]      cnt_q;
  logic [AW-1:0]   reg_addr_q;
  logic [DW-1:0]   reg_wdata_q;
  logic [NREG-1:0] reg_we_q;
  logic [DW-1:0]   rdata_q;
  logic            fault_q;
  logic [AW-1:0]   fault_addr_q;

  logic            dec_hit;
  logic [IW-1:0]   dec_idx;
  logic [NREG-1:0] we_onehot;
  logic            accept;
  logic [2:0]      after_wait;

  mem_router_decode #(
    .NREG   (NREG),
    .AW     (AW),
    .IW     (IW),
    .BASES  (BASES),
    .LIMITS (LIMITS)
  ) u_decode (
    .addr_i (bus.address),
    .hit_o  (dec_hit),
    .idx_o  (dec_idx)
  );

  assign accept     = bus.req && (state_q == S_IDLE || state_q == S_DONE);
  assign after_wait = we_q ? S_DONE : S_CAPTURE;

  always_comb begin
    we_onehot          = '0;
    we_onehot[dec_idx] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (accept) state_d = S_ISSUE;
      S_ISSUE:   state_d = (cnt_q != 4'd0) ? S_WAIT : after_wait;
      S_WAIT:    if (cnt_q == 4'd1) state_d = after_wait;
      S_CAPTURE: state_d = S_DONE;
      S_DONE:    state_d = accept ? S_ISSUE : S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      hit_q        <= 1'b0;
      we_q         <= 1'b0;
      idx_q        <= '0;
      cnt_q        <= '0;
      reg_addr_q   <= '0;
      reg_wdata_q  <= '0;
      reg_we_q     <= '0;
      rdata_q      <= OPEN_BUS;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      state_q  <= state_d;
      reg_we_q <= '0;
      if (accept) begin
        hit_q       <= dec_hit;
        idx_q       <= dec_idx;
        we_q        <= bus.we;
        cnt_q       <= dec_hit ? WAITS[4*int'(dec_idx) +: 4] : 4'd0;
        reg_addr_q  <= bus.address;
        reg_wdata_q <= bus.o_data;
        if (dec_hit && bus.we) reg_we_q <= we_onehot;
      end else if (state_q == S_WAIT) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (state_q == S_CAPTURE)
        rdata_q <= hit_q ? bus.reg_rdata[int'(idx_q)*DW +: DW] : OPEN_BUS;
      // A coincident clear is applied first, so the new fault address still loads.
      if (accept && !dec_hit) begin
        fault_q <= 1'b1;
        if (!fault_q || bus.fault_clr) fault_addr_q <= bus.address;
      end else if (bus.fault_clr) begin
        fault_q <= 1'b0;
      end
    end
  end

  assign bus.ready      = (state_q == S_DONE);
  assign bus.i_data     = rdata_q;
  assign bus.reg_addr   = reg_addr_q;
  assign bus.reg_wdata  = reg_wdata_q;
  assign bus.reg_we     = reg_we_q;
  assign bus.fault      = fault_q;
  assign bus.fault_addr = fault_addr_q;

endmodule

// File: tb/tb_mem_router.sv
// Directed bench for mem_router: board map instance plus an overlapping-region instance.
module tb_mem_router;
  import mem_router_pkg::*;

  localparam logic [79:0] BASES_A  = {20'h00000, 20'h20000, CGA_BASE, RAM_BASE};
  localparam logic [79:0] LIMITS_A = {20'h00000, 20'h20100, CGA_LIM,  RAM_LIM};
  localparam logic [15:0] WAITS_A  = {4'h0, 4'h5, 4'h2, 4'h0};
  localparam logic [39:0] BASES_B  = {20'h08000, 20'h00000};
  localparam logic [39:0] LIMITS_B = {20'h09000, 20'h10000};

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  mem_router_if #(.NREG(4), .AW(20), .DW(8)) ifa ();
  mem_router_if #(.NREG(2), .AW(20), .DW(8)) ifb ();

  mem_router #(
    .NREG(4), .AW(20), .DW(8),
    .BASES(BASES_A), .LIMITS(LIMITS_A), .WAITS(WAITS_A), .OPEN_BUS(8'hFF)
  ) dut_a (.clock(clk), .reset(rst), .bus(ifa));

  mem_router #(
    .NREG(2), .AW(20), .DW(8),
    .BASES(BASES_B), .LIMITS(LIMITS_B), .WAITS(8'h00), .OPEN_BUS(8'hFF)
  ) dut_b (.clock(clk), .reset(rst), .bus(ifb));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM-style region model: data follows reg_addr by one clock.
  always @(posedge clk) begin
    ifa.reg_rdata <= {8'h44, 8'h33, ifa.reg_addr[7:0] ^ 8'h40,
                      (ifa.reg_addr == 20'h01234) ? 8'h5A : (ifa.reg_addr[7:0] ^ 8'h80)};
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One access on instance A, req accepted at the edge ending cycle 0; returns ready cycle (-1 on timeout).
  task automatic access_a(input logic [19:0] addr, input logic [7:0] wd, input logic w,
                          input logic fclr, output int rdy, output logic [3:0] we1,
                          output int nwe, output logic [7:0] rd);
    ifa.req       = 1'b1;
    ifa.address   = addr;
    ifa.o_data    = wd;
    ifa.we        = w;
    ifa.fault_clr = fclr;
    rdy = -1;
    we1 = '0;
    nwe = 0;
    rd  = '0;
    for (int c = 1; c <= 30; c++) begin
      tick();
      ifa.req       = 1'b0;
      ifa.fault_clr = 1'b0;
      if (c == 1) we1 = ifa.reg_we;
      if (ifa.reg_we != '0) nwe++;
      if (ifa.ready) begin
        rdy = c;
        rd  = ifa.i_data;
        break;
      end
    end
  endtask

  initial begin
    int         rdy, nwe, r2;
    logic [3:0] we1;
    logic [7:0] rd;
    int         nready;

    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    ifa.req = 1'b0; ifa.address = '0; ifa.o_data = '0; ifa.we = 1'b0; ifa.fault_clr = 1'b0;
    ifb.req = 1'b0; ifb.address = '0; ifb.o_data = '0; ifb.we = 1'b0; ifb.fault_clr = 1'b0;
    ifb.reg_rdata = 16'hB1B0;
    repeat (3) tick();

    check("rst_ready",      32'(ifa.ready),      32'h0);
    check("rst_i_data",     32'(ifa.i_data),     32'hFF);
    check("rst_reg_addr",   32'(ifa.reg_addr),   32'h0);
    check("rst_reg_wdata",  32'(ifa.reg_wdata),  32'h0);
    check("rst_reg_we",     32'(ifa.reg_we),     32'h0);
    check("rst_fault",      32'(ifa.fault),      32'h0);
    check("rst_fault_addr", 32'(ifa.fault_addr), 32'h0);
    rst = 1'b0;
    tick();

    access_a(20'h01234, 8'h00, 1'b0, 1'b0, rdy, we1, nwe, rd);
    check("rd0_ready_cycle", 32'(rdy), 32'd3);
    check("rd0_no_strobe",   32'(nwe), 32'd0);
    check("rd0_data",        32'(rd),  32'h5A);
    tick();
    check("rd0_ready_pulse", 32'(ifa.ready),  32'h0);
    check("rd0_data_hold",   32'(ifa.i_data), 32'h5A);

    access_a(20'hB8000, 8'h41, 1'b1, 1'b0, rdy, we1, nwe, rd);
    check("wr1_strobe_c1",    32'(we1),           32'h2);
    check("wr1_strobe_count", 32'(nwe),           32'd1);
    check("wr1_ready_cycle",  32'(rdy),           32'd4);
    check("wr1_reg_addr",     32'(ifa.reg_addr),  32'hB8000);
    check("wr1_reg_wdata",    32'(ifa.reg_wdata), 32'h41);
    check("wr1_i_data_hold",  32'(ifa.i_data),    32'h5A);
    tick();

    access_a(20'hB9FFF, 8'h00, 1'b0, 1'b0, rdy, we1, nwe, rd);
    check("rd1_ready_cycle", 32'(rdy), 32'd5);
    check("rd1_data",        32'(rd),  32'hBF);
    check("rd1_no_fault",    32'(ifa.fault), 32'h0);
    tick();

    access_a(20'h08000, 8'h00, 1'b0, 1'b0, rdy, we1, nwe, rd);
    check("unm_rd_ready_cycle", 32'(rdy),            32'd3);
    check("unm_rd_data",        32'(rd),             32'hFF);
    check("unm_rd_fault",       32'(ifa.fault),      32'h1);
    check("unm_rd_fault_addr",  32'(ifa.fault_addr), 32'h08000);
    tick();

    access_a(20'h09000, 8'h00, 1'b0, 1'b0, rdy, we1, nwe, rd);
    check("unm_rd2_data",       32'(rd),             32'hFF);
    check("unm_rd2_fault_addr", 32'(ifa.fault_addr), 32'h08000);
    tick();

    access_a(20'hBA000, 8'h00, 1'b0, 1'b0, rdy, we1, nwe, rd);
    check("cga_limit_ready_cycle", 32'(rdy), 32'd3);
    check("cga_limit_data",        32'(rd),  32'hFF);
    tick();

    access_a(20'h50000, 8'h77, 1'b1, 1'b0, rdy, we1, nwe, rd);
    check("unm_wr_no_strobe",   32'(nwe), 32'd0);
    check("unm_wr_ready_cycle", 32'(rdy), 32'd2);
    tick();

    ifa.fault_clr = 1'b1;
    tick();
    ifa.fault_clr = 1'b0;
    check("clr_fault",      32'(ifa.fault),      32'h0);
    check("clr_fault_addr", 32'(ifa.fault_addr), 32'h08000);

    access_a(20'h30000, 8'h00, 1'b0, 1'b1, rdy, we1, nwe, rd);
    check("clr_set_fault",      32'(ifa.fault),      32'h1);
    check("clr_set_fault_addr", 32'(ifa.fault_addr), 32'h30000);
    tick();

    access_a(20'h40000, 8'h00, 1'b0, 1'b1, rdy, we1, nwe, rd);
    check("clr_set2_fault",      32'(ifa.fault),      32'h1);
    check("clr_set2_fault_addr", 32'(ifa.fault_addr), 32'h40000);
    tick();

    // Second request presented during DONE (cycle 3): ISSUE in cycle 4, ready three cycles after accept.
    ifa.req = 1'b1; ifa.address = 20'h00010; ifa.we = 1'b0;
    r2 = -1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 1) ifa.req = 1'b0;
      if (c == 3) begin
        check("b2b_ready1", 32'(ifa.ready),  32'h1);
        check("b2b_data1",  32'(ifa.i_data), 32'h90);
        ifa.req = 1'b1;
        ifa.address = 20'h00011;
      end
      if (c == 4) begin
        check("b2b_issue", 32'(dut_a.state_q), 32'(S_ISSUE));
        check("b2b_gap",   32'(ifa.ready),     32'h0);
        ifa.req = 1'b0;
      end
      if (c > 4 && ifa.ready) begin
        r2 = c;
        check("b2b_data2", 32'(ifa.i_data), 32'h91);
        break;
      end
    end
    check("b2b_ready2_cycle", 32'(r2), 32'd6);
    tick();

    ifb.req = 1'b1; ifb.address = 20'h08800; ifb.o_data = 8'h3C; ifb.we = 1'b1;
    tick();
    ifb.req = 1'b0;
    check("ovl_strobe", 32'(ifb.reg_we), 32'h1);
    tick();
    check("ovl_ready", 32'(ifb.ready), 32'h1);
    tick();

    ifb.req = 1'b1; ifb.address = 20'h0FFFF; ifb.we = 1'b0;
    tick();
    ifb.req = 1'b0;
    tick();
    tick();
    check("ovl_rd_ready", 32'(ifb.ready),  32'h1);
    check("ovl_rd_data",  32'(ifb.i_data), 32'hB0);
    tick();

    // Reset lands in the WAIT phase of a W=5 read.
    ifa.req = 1'b1; ifa.address = 20'h20010; ifa.we = 1'b0;
    tick();
    ifa.req = 1'b0;
    tick();
    tick();
    check("rst_mid_in_wait", 32'(dut_a.state_q), 32'(S_WAIT));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_idle",   32'(dut_a.state_q), 32'(S_IDLE));
    check("rst_mid_we",     32'(ifa.reg_we),    32'h0);
    check("rst_mid_fault",  32'(ifa.fault),     32'h0);
    nready = 0;
    for (int c = 0; c < 10; c++) begin
      if (ifa.ready) nready++;
      tick();
    end
    check("rst_mid_no_ready", 32'(nready), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
